// File: rtl/uno_pkg.sv
// Shared types and helpers for the unary-op scheduler slice.
package uno_pkg;

    typedef enum logic [1:0] {
        UNO_GEMM = 2'b00,
        UNO_DIV  = 2'b01,
        UNO_EXP  = 2'b10,
        UNO_LOG  = 2'b11
    } uno_op_e;

    localparam int unsigned UNO_FIFO_DEPTH = 2;

    // Modulo-n increment used for the round-robin pointer.
    function automatic int unsigned uno_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uno_sched_if.sv
// Requester/response bundle between the PE lane front-ends and uno_sched.
interface uno_sched_if #(
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ID_BW  = $clog2(NREQ)
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][1:0]        req_op;
    logic [NREQ-1:0][MUL_BW-1:0] req_x;
    logic [NREQ-1:0][MUL_BW-1:0] req_y;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_BW-1:0]            rsp_id;
    logic [1:0]                  rsp_op;
    logic signed [MUL_BW-1:0]    rsp_scale;

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_op, rsp_scale
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_op, rsp_scale
    );
endinterface

// File: rtl/uno_sched_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after ptr.
module rr_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_BW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [ID_BW-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [ID_BW-1:0] gnt_idx
);

    always_comb begin
        int unsigned pos;
        logic [ID_BW-1:0] idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // ptr is always below NREQ, so one subtraction wraps the search
            pos = 32'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = ID_BW'(pos);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uno_sched.sv
// Shares one scale_gen among NREQ requesters: round-robin issue, 1-cycle
// tag tracking and a 2-entry result FIFO with credit-based issue control.
module uno_sched
    import uno_pkg::*;
#(
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ID_BW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    uno_sched_if.slave               bus,
    output logic [1:0]               sg_op_o,
    output logic signed [MUL_BW-1:0] sg_x_o,
    output logic signed [MUL_BW-1:0] sg_y_o,
    input  logic signed [MUL_BW-1:0] sg_scale_i,
    output logic                     busy
);

    typedef struct packed {
        logic [ID_BW-1:0]  id;
        uno_op_e           op;
        logic [MUL_BW-1:0] scale;
    } entry_t;

    logic [1:0]       occ;
    logic             inflight;
    logic [ID_BW-1:0] rr_ptr;
    logic [ID_BW-1:0] tag_id;
    uno_op_e          tag_op;
    entry_t           fifo_mem [UNO_FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    entry_t           head;

    logic [NREQ-1:0]  gnt;
    logic [ID_BW-1:0] gnt_idx;
    logic             accept;
    logic             push;
    logic             pop;
    logic [2:0]       credit_used;
    logic             can_issue;

    assign bus.rsp_valid = (occ != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign push          = inflight;

    // A same-cycle pop frees a slot, so issue may proceed even when full.
    assign credit_used = 3'(occ) + 3'(inflight) - 3'(pop);
    assign can_issue   = (credit_used < 3'd2);

    rr_arb #(
        .NREQ  (NREQ),
        .ID_BW (ID_BW)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (can_issue & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign accept        = |gnt;

    always_comb begin
        sg_op_o = 2'b00;
        sg_x_o  = '0;
        sg_y_o  = '0;
        if (accept) begin
            sg_op_o = bus.req_op[gnt_idx];
            sg_x_o  = bus.req_x[gnt_idx];
            sg_y_o  = bus.req_y[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= '0;
            inflight <= 1'b0;
            rr_ptr   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= accept;
            occ      <= occ + 2'(push) - 2'(pop);
            if (accept) rr_ptr <= ID_BW'(uno_wrap_inc(32'(gnt_idx), NREQ));
            if (push)   wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_id <= gnt_idx;
            tag_op <= uno_op_e'(bus.req_op[gnt_idx]);
        end
        if (push && !rst) fifo_mem[wr_ptr] <= '{id: tag_id, op: tag_op, scale: sg_scale_i};
    end

    assign head          = fifo_mem[rd_ptr];
    assign bus.rsp_id    = head.id;
    assign bus.rsp_op    = head.op;
    assign bus.rsp_scale = head.scale;

    assign busy = inflight | (occ != '0);

endmodule

// File: tb/tb_uno_sched.sv
// Self-checking bench for uno_sched: queue-based reference model checked every
// cycle plus directed scenarios with literal expectations.
module tb_uno_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]           sg_op;
    logic signed [BW-1:0] sg_x, sg_y;
    logic signed [BW-1:0] sg_scale;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    uno_sched_if #(.MUL_BW(BW), .NREQ(N)) bus ();

    uno_sched #(.MUL_BW(BW), .NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sg_op_o    (sg_op),
        .sg_x_o     (sg_x),
        .sg_y_o     (sg_y),
        .sg_scale_i (sg_scale),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for scale_gen: arbitrary but distinct per op, gemm yields 0.
    function automatic logic [BW-1:0] sg_f(input logic [1:0] op, input logic [BW-1:0] x, input logic [BW-1:0] y);
        case (op)
            2'b01:   return x ^ y;
            2'b10:   return x + y;
            2'b11:   return x - y;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) sg_scale <= sg_f(sg_op, sg_x, sg_y);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            id;
        logic [1:0]    op;
        logic [BW-1:0] scale;
    } ent_t;

    ent_t q[$];
    ent_t pend[$];
    int   acc_log[$];
    int   pop_log[$];
    int   mptr = 0;

    // Reference model: results queue, at most one in flight, credit of two.
    initial begin
        @(posedge clk);
        forever begin
            logic        ev, pop, can, found;
            int          g;
            logic [N-1:0] exp_rdy;
            logic [1:0]  eop;
            logic [BW-1:0] ex, ey;
            ent_t        e;
            @(negedge clk);
            ev = (q.size() != 0);
            chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(ev));
            if (ev) begin
                chk("m_rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
                chk("m_rsp_op", 32'(bus.rsp_op), 32'(q[0].op));
                chk("m_rsp_scale", 32'($unsigned(bus.rsp_scale)), 32'(q[0].scale));
            end
            pop   = ev && bus.rsp_ready;
            can   = (q.size() + pend.size() - (pop ? 1 : 0)) < 2;
            found = 1'b0;
            g     = 0;
            if (!rst && can)
                for (int k = 0; k < N; k++)
                    if (!found && bus.req_valid[(mptr + k) % N]) begin
                        found = 1'b1;
                        g     = (mptr + k) % N;
                    end
            exp_rdy = found ? N'(1 << g) : '0;
            eop = found ? bus.req_op[g] : 2'b00;
            ex  = found ? bus.req_x[g] : '0;
            ey  = found ? bus.req_y[g] : '0;
            chk("m_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("m_sg_op", 32'(sg_op), 32'(eop));
            chk("m_sg_x", 32'($unsigned(sg_x)), 32'(ex));
            chk("m_sg_y", 32'($unsigned(sg_y)), 32'(ey));
            chk("m_busy", 32'(busy), 32'((q.size() != 0) || (pend.size() != 0)));
            if (rst) begin
                q.delete();
                pend.delete();
                mptr = 0;
            end else begin
                if (pop) begin
                    pop_log.push_back(q[0].id);
                    void'(q.pop_front());
                end
                if (pend.size() != 0) begin
                    q.push_back(pend[0]);
                    pend.delete();
                end
                if (found) begin
                    e.id = g; e.op = eop; e.scale = sg_f(eop, ex, ey);
                    pend.push_back(e);
                    acc_log.push_back(g);
                    mptr = (g + 1) % N;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        cyc();
        rst = 1'b0;
        acc_log.delete();
        pop_log.delete();
    endtask

    initial begin
        bus.req_valid = '1;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;

        // Single div request from requester 2
        cyc();
        bus.req_valid = 4'b0100;
        bus.req_op[2] = 2'b01;
        bus.req_x[2]  = 16'h0800;
        bus.req_y[2]  = 16'h4000;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_req_ready", 32'(bus.req_ready), 32'h4);
        chk("single_sg_op", 32'(sg_op), 32'h1);
        chk("single_sg_x", 32'($unsigned(sg_x)), 32'h0800);
        cyc();
        bus.req_valid = '0;
        cyc();
        @(negedge clk);
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(bus.rsp_id), 32'd2);
        chk("single_rsp_scale", 32'($unsigned(bus.rsp_scale)), 32'h4800);
        cyc();
        @(negedge clk);
        chk("idle_sg_op", 32'(sg_op), 32'd0);
        chk("idle_sg_x", 32'($unsigned(sg_x)), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Gemm returns zero; pointer wrapped from 3 to 0
        cyc();
        bus.req_valid = 4'b0001;
        bus.req_op[0] = 2'b00;
        bus.req_x[0]  = 16'h1234;
        bus.req_y[0]  = 16'h5678;
        @(negedge clk);
        chk("gemm_req_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = '0;
        cyc();
        @(negedge clk);
        chk("gemm_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("gemm_rsp_op", 32'(bus.rsp_op), 32'd0);
        chk("gemm_rsp_scale", 32'($unsigned(bus.rsp_scale)), 32'd0);

        // Fairness: all valid, one grant per cycle in rotation
        do_reset();
        cyc();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i] = 2'(i);
            bus.req_x[i]  = 16'(16'h0100 * (i + 1));
            bus.req_y[i]  = 16'(16'h0003 + i);
        end
        repeat (8) cyc();
        bus.req_valid = '0;
        repeat (4) cyc();
        chk("fair_acc_n", 32'(acc_log.size()), 32'd8);
        chk("fair_pop_n", 32'(pop_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size() && i < pop_log.size(); i++) begin
            chk("fair_acc_id", 32'(acc_log[i]), 32'(i % 4));
            chk("fair_pop_id", 32'(pop_log[i]), 32'(i % 4));
        end

        // Backpressure: two accepts fill the credit, then pop+accept together
        do_reset();
        cyc();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0111;
        repeat (4) cyc();
        @(negedge clk);
        chk("bp_req_ready_zero", 32'(bus.req_ready), 32'd0);
        chk("bp_acc_n", 32'(acc_log.size()), 32'd2);
        cyc();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_pop_id", 32'(bus.rsp_id), 32'd0);
        chk("bp_accept_with_pop", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = '0;
        repeat (4) cyc();
        chk("bp_total_pops", 32'(pop_log.size()), 32'd3);

        // Reset the cycle after an accept drops the in-flight result
        do_reset();
        cyc();
        bus.req_valid = 4'b0010;
        bus.req_op[1] = 2'b10;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rmid_req_ready", 32'(bus.req_ready), 32'h2);
        cyc();
        rst = 1'b1;
        bus.req_valid = '0;
        cyc();
        rst = 1'b0;
        acc_log.delete();
        pop_log.delete();
        bus.req_valid = '1;
        @(negedge clk);
        chk("rmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_ptr_zero", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = '0;
        repeat (4) cyc();
        chk("rmid_pops", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() != 0) chk("rmid_pop_id", 32'(pop_log[0]), 32'd0);

        // Random traffic with random backpressure against the model
        do_reset();
        for (int c = 0; c < 30; c++) begin
            cyc();
            bus.req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.req_op[i] = 2'($urandom);
                bus.req_x[i]  = 16'($urandom);
                bus.req_y[i]  = 16'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (5) cyc();
        chk("rand_no_loss", 32'(pop_log.size()), 32'(acc_log.size()));
        @(negedge clk);
        chk("rand_drained_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
